// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with early pixel request
//
// Purpose:
//   Runs horizontal/vertical raster counters in the pixel clock domain. It issues an
//   early pixel request (REQ/REQ_X/REQ_Y) to the framebuffer reader. After PIPE_DLY
//   enabled stages, the matching sync, valid, position and strobe outputs line up with
//   the read data.
//
// Ports:
//   VGA_CLK      in   pixel clock, rising edge
//   VGA_RST      in   synchronous reset, active high, has priority over CLK_EN
//   CLK_EN       in   pixel enable; all state holds while low
//   REQ          out  pixel request, PIPE_DLY enabled cycles ahead of valid
//   REQ_X/REQ_Y  out  column/row of the request, 0 when REQ=0
//   VGA_HS/VS    out  syncs, asserted level set by HS_POL/VS_POL
//   valid        out  active-video flag
//   X/Y          out  active column/row, 0 when valid=0
//   frame_start  out  strobe on pixel (0,0)
//   line_start   out  strobe on X=0 of every active line
//   frame_cnt    out  completed frames (counter only when VGA_TIMING_FRAME_CNT_EN is defined)
//
// Build option: VGA_TIMING_FRAME_CNT_EN enables the 16-bit frame counter.

module vga_timing_gen #(
  parameter int P_WIDTH  = 11,
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input  logic               VGA_CLK,
  input  logic               VGA_RST,
  input  logic               CLK_EN,
  output logic               REQ,
  output logic [P_WIDTH-1:0] REQ_X,
  output logic [P_WIDTH-1:0] REQ_Y,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               valid,
  output logic [P_WIDTH-1:0] X,
  output logic [P_WIDTH-1:0] Y,
  output logic               frame_start,
  output logic               line_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [P_WIDTH-1:0] H_LAST     = P_WIDTH'(H_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] V_LAST     = P_WIDTH'(V_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] H_ACT_BEG  = P_WIDTH'(H_SYNC + H_BACK);
  localparam logic [P_WIDTH-1:0] H_ACT_END  = P_WIDTH'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [P_WIDTH-1:0] V_ACT_BEG  = P_WIDTH'(V_SYNC + V_BACK);
  localparam logic [P_WIDTH-1:0] V_ACT_END  = P_WIDTH'(V_SYNC + V_BACK + V_ACT - 1);
  localparam logic [P_WIDTH-1:0] H_SYNC_END = P_WIDTH'(H_SYNC);
  localparam logic [P_WIDTH-1:0] V_SYNC_END = P_WIDTH'(V_SYNC);

  // Delay-line word: {hs_active, vs_active, valid, x, y, frame_start, line_start}
  localparam int W_DLY = 5 + 2 * P_WIDTH;

  logic [P_WIDTH-1:0] r_cnt_h;
  logic [P_WIDTH-1:0] r_cnt_v;

  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (CLK_EN) begin
      if (r_cnt_h == H_LAST) begin
        r_cnt_h <= '0;
        if (r_cnt_v == V_LAST) r_cnt_v <= '0;
        else                   r_cnt_v <= r_cnt_v + 1'b1;
      end else begin
        r_cnt_h <= r_cnt_h + 1'b1;
      end
    end
  end

  // Decode of the current counter value; captured into stage 0 on the next enabled edge.
  logic               w_req;
  logic [P_WIDTH-1:0] w_req_x;
  logic [P_WIDTH-1:0] w_req_y;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_line;
  logic               w_frame;

  assign w_req    = (r_cnt_h >= H_ACT_BEG) && (r_cnt_h <= H_ACT_END) &&
                    (r_cnt_v >= V_ACT_BEG) && (r_cnt_v <= V_ACT_END);
  assign w_req_x  = w_req ? (r_cnt_h - H_ACT_BEG) : '0;
  assign w_req_y  = w_req ? (r_cnt_v - V_ACT_BEG) : '0;
  assign w_hs_act = (r_cnt_h < H_SYNC_END);
  assign w_vs_act = (r_cnt_v < V_SYNC_END);
  assign w_line   = w_req && (w_req_x == '0);
  assign w_frame  = w_line && (w_req_y == '0);

  logic               r_req;
  logic [P_WIDTH-1:0] r_req_x;
  logic [P_WIDTH-1:0] r_req_y;
  logic               r_hs0;
  logic               r_vs0;
  logic               r_ls0;
  logic               r_fs0;

  // Syncs are kept as active-high "asserted" bits internally so that a flushed
  // (all-zero) pipeline always maps to the inactive output level.
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST) begin
      r_req   <= 1'b0;
      r_req_x <= '0;
      r_req_y <= '0;
      r_hs0   <= 1'b0;
      r_vs0   <= 1'b0;
      r_ls0   <= 1'b0;
      r_fs0   <= 1'b0;
    end else if (CLK_EN) begin
      r_req   <= w_req;
      r_req_x <= w_req_x;
      r_req_y <= w_req_y;
      r_hs0   <= w_hs_act;
      r_vs0   <= w_vs_act;
      r_ls0   <= w_line;
      r_fs0   <= w_frame;
    end
  end

  assign REQ   = r_req;
  assign REQ_X = r_req_x;
  assign REQ_Y = r_req_y;

  logic [W_DLY-1:0] w_s0;
  logic [W_DLY-1:0] w_out;

  assign w_s0 = {r_hs0, r_vs0, r_req, r_req_x, r_req_y, r_fs0, r_ls0};

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign w_out = w_s0;
    end else begin : g_dly
      logic [W_DLY-1:0] r_dly [PIPE_DLY];

      always_ff @(posedge VGA_CLK) begin
        if (VGA_RST) begin
          for (int i = 0; i < PIPE_DLY; i++) r_dly[i] <= '0;
        end else if (CLK_EN) begin
          r_dly[0] <= w_s0;
          for (int i = 1; i < PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
        end
      end

      assign w_out = r_dly[PIPE_DLY-1];
    end
  endgenerate

  logic w_hs_d;
  logic w_vs_d;

  assign {w_hs_d, w_vs_d, valid, X, Y, frame_start, line_start} = w_out;

  assign VGA_HS = w_hs_d ? HS_POL : ~HS_POL;
  assign VGA_VS = w_vs_d ? VS_POL : ~VS_POL;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Gated by CLK_EN because the strobe stays high across disabled cycles.
  always_ff @(posedge VGA_CLK) begin
    if (VGA_RST)                      r_frame_cnt <= 16'd0;
    else if (CLK_EN && frame_start)   r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Instance outputs: d0 = PIPE_DLY 0, d3 = PIPE_DLY 3, dp = PIPE_DLY 0 with inverted polarity
  logic        req0, req3, reqp;
  logic [10:0] rx0, ry0, rx3, ry3, rxp, ryp;
  logic        hs0, vs0, v0, fs0, ls0;
  logic        hs3, vs3, v3, fs3, ls3;
  logic        hsp, vsp, vp, fsp, lsp;
  logic [10:0] x0, y0, x3, y3, xp, yp;
  logic [15:0] fc0, fc3, fcp;

  vga_timing_gen #(.P_WIDTH(11), .H_ACT(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)) u_dut0 (
    .VGA_CLK(clk), .VGA_RST(rst), .CLK_EN(en),
    .REQ(req0), .REQ_X(rx0), .REQ_Y(ry0),
    .VGA_HS(hs0), .VGA_VS(vs0), .valid(v0), .X(x0), .Y(y0),
    .frame_start(fs0), .line_start(ls0), .frame_cnt(fc0));

  vga_timing_gen #(.P_WIDTH(11), .H_ACT(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)) u_dut3 (
    .VGA_CLK(clk), .VGA_RST(rst), .CLK_EN(en),
    .REQ(req3), .REQ_X(rx3), .REQ_Y(ry3),
    .VGA_HS(hs3), .VGA_VS(vs3), .valid(v3), .X(x3), .Y(y3),
    .frame_start(fs3), .line_start(ls3), .frame_cnt(fc3));

  vga_timing_gen #(.P_WIDTH(11), .H_ACT(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_ACT(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)) u_dutp (
    .VGA_CLK(clk), .VGA_RST(rst), .CLK_EN(en),
    .REQ(reqp), .REQ_X(rxp), .REQ_Y(ryp),
    .VGA_HS(hsp), .VGA_VS(vsp), .valid(vp), .X(xp), .Y(yp),
    .frame_start(fsp), .line_start(lsp), .frame_cnt(fcp));

  wire [26:0] o0 = {hs0, vs0, v0, x0, y0, fs0, ls0};
  wire [26:0] o3 = {hs3, vs3, v3, x3, y3, fs3, ls3};
  wire [26:0] op = {hsp, vsp, vp, xp, yp, fsp, lsp};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Expected output word for raster position c (enabled edges since reset minus delay).
  // Small timing: H line = sync 0..1, back 2, active 3..6, front 7; V frame = sync 0,
  // back 1, active 2..4, front 5.
  function automatic logic [26:0] model(input int c, input bit hp, input bit vp_);
    int h, v;
    logic act, hs_a, vs_a, ls, fs;
    logic [10:0] xx, yy;
    if (c < 0) return {~hp, ~vp_, 25'd0};
    h    = c % 8;
    v    = (c / 8) % 6;
    act  = (h >= 3) && (h <= 6) && (v >= 2) && (v <= 4);
    xx   = act ? 11'(h - 3) : 11'd0;
    yy   = act ? 11'(v - 2) : 11'd0;
    hs_a = (h < 2);
    vs_a = (v < 1);
    ls   = act && (xx == 0);
    fs   = ls && (yy == 0);
    return {hs_a ? hp : ~hp, vs_a ? vp_ : ~vp_, act, xx, yy, fs, ls};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst)     k = 0;
    else if (en) k++;
  endtask

  task automatic check_all(input string tag);
    logic [26:0] m;
    m = model(k - 1, 1'b0, 1'b0);
    check({tag, "_d0"}, o0, m);
    check({tag, "_d3"}, o3, model(k - 4, 1'b0, 1'b0));
    check({tag, "_req3"}, {req3, rx3, ry3}, m[24:2]);
    check({tag, "_pol"}, op, model(k - 1, 1'b1, 1'b1));
  endtask

  initial begin
    int n_valid, n_hs_low, n_vs_low, n_fs0, n_fs3, k_fs;
    logic [10:0] ex, ey;
    logic [15:0] fc_exp;

    // Reset state
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    check("rst_d0", o0, {2'b11, 25'd0});
    check("rst_d3", o3, {2'b11, 25'd0});
    check("rst_pol", op, 27'd0);
    check("rst_req", {req0, rx0, ry0, req3}, 24'd0);
    check("rst_fcnt", fc0, 16'd0);

    // Test 1/2/3: one frame plus pipeline drain, PIPE_DLY 0 and 3, both polarities
    rst = 1'b0;
    n_valid = 0; n_hs_low = 0; n_vs_low = 0; ex = 0; ey = 0;
    for (int i = 0; i < 51; i++) begin
      tick();
      check_all("t1");
      if (k <= 48) begin
        if (v0) begin
          check("t1_raster", {x0, y0}, {ex, ey});
          ex = ex + 1'b1;
          if (ex == 11'd4) begin ex = 0; ey = ey + 1'b1; end
        end
        n_valid  += int'(v0);
        n_hs_low += int'(!hs0);
        if (k <= 8) n_vs_low += int'(!vs0);
      end
    end
    check("t1_nvalid", n_valid, 12);
    check("t1_hs_low", n_hs_low, 12);
    check("t1_vs_low", n_vs_low, 8);

    // Test 4: CLK_EN toggling, frame takes 96 clocks
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 96; i++) begin
      en = (i % 2 == 0);
      tick();
      check_all("t4");
    end
    check("t4_k", k, 48);

    // Test 5: reset mid-active at X=2,Y=1, with CLK_EN low to show reset priority
    en = 1'b1;
    while (k < 78) begin
      tick();
      check_all("t5_run");
    end
    check("t5_pre", {v0, x0, y0}, {1'b1, 11'd2, 11'd1});
    rst = 1'b1; en = 1'b0;
    tick();
    check("t5_rst_d0", o0, {2'b11, 25'd0});
    check("t5_rst_d3", o3, {2'b11, 25'd0});
    rst = 1'b0; en = 1'b1;
    k_fs = -1;
    for (int i = 0; i < 100 && k_fs < 0; i++) begin
      tick();
      check_all("t5");
      if (fs0) k_fs = k;
    end
    check("t5_fs_k", k_fs, 20);

    // Test 6: three frames, frame_start pulse count and frame_cnt
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    n_fs0 = 0; n_fs3 = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      n_fs0 += int'(fs0);
      n_fs3 += int'(fs3);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc_exp = 16'd3;
`else
    fc_exp = 16'd0;
`endif
    check("t6_fs0", n_fs0, 3);
    check("t6_fs3", n_fs3, 3);
    check("t6_fcnt0", fc0, fc_exp);
    check("t6_fcnt3", fc3, fc_exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1, "timeout");
  end

endmodule
